// File: rtl/mem_init_loader.sv
// Streams a data-memory image into the datapath init port while the core is held in reset,
// then releases the core after a programmable settle interval.
module mem_init_loader #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  word_count,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        data_init_write_enable,
  output logic [7:0]  data_init_addr,
  output logic [31:0] data_init_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

  state_t      state;
  state_t      state_next;
  logic        armed;
  logic [7:0]  ptr;
  logic [8:0]  remaining;
  logic [7:0]  hold_cnt;

  logic        can_start;
  logic        start_ok;
  logic        start_bad;
  logic        accept;
  logic        final_beat;
  logic        early_end;

  logic        s_ready_d;
  logic        we_d;
  logic        cpu_reset_d;
  logic        busy_d;
  logic        done_d;
  logic        error_d;

  // The first edge after reset release only arms the loader, so a start seen there is dropped
  assign can_start  = armed && start && ((state == IDLE) || (state == RUN));
  assign start_ok   = can_start && (word_count != 9'd0);
  assign start_bad  = can_start && (word_count == 9'd0);
  assign accept     = (state == LOAD) && s_valid;
  assign final_beat = accept && (remaining == 9'd1);
  assign early_end  = accept && s_last && (remaining > 9'd1);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, RUN: begin
        if (start_ok) begin
          state_next = LOAD;
        end else if (start_bad) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (final_beat) begin
          state_next = HOLD;
        end else if (early_end) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered copies of the state being entered
  always_comb begin
    s_ready_d   = (state_next == LOAD);
    busy_d      = (state_next == LOAD) || (state_next == HOLD);
    done_d      = (state_next == RUN);
    cpu_reset_d = (state_next != RUN);
    we_d        = accept && !early_end;
    error_d     = error;
    if (start_ok) begin
      error_d = 1'b0;
    end else if (start_bad || early_end) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      armed                  <= 1'b0;
      ptr                    <= 8'd0;
      remaining              <= 9'd0;
      hold_cnt               <= 8'd0;
      s_ready                <= 1'b0;
      data_init_write_enable <= 1'b0;
      data_init_addr         <= 8'd0;
      data_init_data         <= 32'd0;
      cpu_reset              <= 1'b1;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
    end else begin
      state                  <= state_next;
      armed                  <= 1'b1;
      s_ready                <= s_ready_d;
      data_init_write_enable <= we_d;
      cpu_reset              <= cpu_reset_d;
      busy                   <= busy_d;
      done                   <= done_d;
      error                  <= error_d;
      if (we_d) begin
        data_init_addr <= ptr;
        data_init_data <= s_data;
      end
      if (start_ok) begin
        ptr       <= base_addr;
        remaining <= word_count;
      end else if (accept) begin
        ptr       <= ptr + 8'd1;
        remaining <= remaining - 9'd1;
      end
      // Zero in the strobe cycle, so RUN begins HOLD_CYCLES cycles after the final strobe ends
      hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
    end
  end

endmodule

// File: doc/mem_init_loader.md
MEM_INIT_LOADER -- requirements
Module: mem_init_loader

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles cpu_reset stays high after the last data-memory write, before the core is released (legal 1..255).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  single-cycle load request.
REQ-005 base_addr  input  8  first data-memory word address, sampled on accepted start.
REQ-006 word_count  input  9  number of words to load (1..256), sampled on accepted start.
REQ-007 s_valid  input  1  stream beat valid.
REQ-008 s_data  input  32  stream beat payload.
REQ-009 s_last  input  1  marks final beat of the stream.
REQ-010 s_ready  output  1  loader accepts a beat this cycle.
REQ-011 data_init_write_enable  output  1  write strobe to the datapath data-memory init port.
REQ-012 data_init_addr  output  8  init write address.
REQ-013 data_init_data  output  32  init write data.
REQ-014 cpu_reset  output  1  active-high reset driven into the datapath/program counter.
REQ-015 busy  output  1  high in LOAD and HOLD.
REQ-016 done  output  1  high in RUN.
REQ-017 error  output  1  sticky protocol-error flag.

Function
REQ-018 States: IDLE, LOAD, HOLD, RUN; all outputs registered.
REQ-019 IDLE: s_ready=0, cpu_reset=1, busy=0, done=0.
REQ-020 IDLE or RUN, start=1 and word_count!=0: latch base_addr into the address pointer and word_count into the remaining counter, clear error, go to LOAD; cpu_reset=1 from the next cycle.
REQ-021 IDLE or RUN, start=1 and word_count=0: set error=1, stay in or return to IDLE, no write issued.
REQ-022 start is ignored in LOAD and HOLD.
REQ-023 LOAD: s_ready=1; beat accepted when s_valid=1 and s_ready=1.
REQ-024 Accepted beat: on the following cycle, data_init_write_enable=1 for exactly one cycle, with data_init_addr=pointer and data_init_data=s_data; write latency 1 cycle; back-to-back beats give back-to-back strobes.
REQ-025 After each accepted beat: pointer increments modulo 256 (255 wraps to 0), remaining decrements by 1.
REQ-026 Beat accepted with remaining=1: final beat; s_ready drops on the next cycle; go to HOLD; s_last value ignored.
REQ-027 Beat accepted with s_last=1 and remaining>1: early termination; beat discarded (no strobe), error=1, go to IDLE.
REQ-028 s_valid=0 in LOAD: no state change and no strobe; wait indefinitely.
REQ-029 HOLD: s_ready=0, cpu_reset=1; hold counter counts HOLD_CYCLES cycles starting in the cycle after the final strobe, then go to RUN.
REQ-030 RUN: cpu_reset=0, done=1, s_ready=0, data_init_write_enable=0.
REQ-031 data_init_addr and data_init_data hold their last values when no strobe is issued.

Reset
REQ-032 reset=0 forces immediately, regardless of clk: state=IDLE, s_ready=0, data_init_write_enable=0, data_init_addr=0, data_init_data=0, cpu_reset=1, busy=0, done=0, error=0, all counters 0.
REQ-033 reset asserted mid-LOAD or mid-HOLD abandons the load; any pending strobe is dropped.
REQ-034 Deassertion of reset takes effect on the next rising clk edge; no start is accepted in the same edge.

Verification
REQ-035 Scenario: base_addr=0x10, word_count=3, beats 0xA,0xB,0xC back-to-back -> strobes to 0x10/0x11/0x12 on consecutive cycles, each one cycle after its beat; cpu_reset falls exactly 4 cycles after the last strobe; done=1.
REQ-036 Scenario: base_addr=0xFE, word_count=4 -> write addresses 0xFE,0xFF,0x00,0x01.
REQ-037 Scenario: word_count=3, s_last=1 on beat 2 -> one strobe only, error=1, IDLE, cpu_reset stays 1.
REQ-038 Scenario: start with word_count=0 -> error=1, no strobe, busy stays 0; next valid start clears error.
REQ-039 Scenario: s_valid toggling 1,0,0,1 with word_count=2 -> exactly 2 strobes, no strobe in the idle gaps.
REQ-040 Scenario: reset=0 asynchronously in mid-LOAD -> all outputs reach reset values before the next clk edge; cpu_reset=1.
